// File: rtl/data_reg_bank_pkg.sv
// Shared constants and types for the ten-entry data register bank.
package data_reg_bank_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 10;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned LAST_ADDR = 9;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // True when the address selects one of the implemented registers.
    function automatic logic addr_in_range(input addr_t addr);
        return addr <= ADDR_W'(LAST_ADDR);
    endfunction

endpackage

// File: rtl/data_reg_bank_if.sv
// Bus bundle for data_reg_bank: load sources, addressed write port and register outputs.
// Optional addrErr signal exists only when DATA_REG_BANK_ADDR_ERR_EN is defined.
interface data_reg_bank_if;
    import data_reg_bank_pkg::*;

    data_t in0, in1, in2, in3, in4, in5, in6, in7, in8, in9;
    data_t dataIn;
    addr_t address;
    logic  writeAddress;
    logic  writeAll;
    data_t out0, out1, out2, out3, out4, out5, out6, out7, out8, out9;
`ifdef DATA_REG_BANK_ADDR_ERR_EN
    logic  addrErr;
`endif

    modport master (
        output in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
        output dataIn, address, writeAddress, writeAll,
`ifdef DATA_REG_BANK_ADDR_ERR_EN
        input  addrErr,
`endif
        input  out0, out1, out2, out3, out4, out5, out6, out7, out8, out9
    );

    modport slave (
        input  in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
        input  dataIn, address, writeAddress, writeAll,
`ifdef DATA_REG_BANK_ADDR_ERR_EN
        output addrErr,
`endif
        output out0, out1, out2, out3, out4, out5, out6, out7, out8, out9
    );

endinterface

// File: rtl/data_reg_bank_cell.sv
// One bank register: synchronous active-low reset, then parallel load, then write, else hold.
module data_reg_cell
    import data_reg_bank_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  data_t load_val_i,
    input  logic  wr_en_i,
    input  data_t wr_val_i,
    output data_t q_o
);

    data_t data_d;
    data_t data_q;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (wr_en_i) begin
            data_d = wr_val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/data_reg_bank.sv
// Ten 32-bit registers with addressed write and parallel load, all contents on dedicated outputs.
// Define DATA_REG_BANK_ADDR_ERR_EN to add the registered addrErr out-of-range write flag.
module data_reg_bank
    import data_reg_bank_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    data_reg_bank_if.slave  bus
);

    data_t                load_val [NUM_REGS];
    data_t                reg_q    [NUM_REGS];
    logic [NUM_REGS-1:0]  wr_en_c;

    assign load_val[0] = bus.in0;
    assign load_val[1] = bus.in1;
    assign load_val[2] = bus.in2;
    assign load_val[3] = bus.in3;
    assign load_val[4] = bus.in4;
    assign load_val[5] = bus.in5;
    assign load_val[6] = bus.in6;
    assign load_val[7] = bus.in7;
    assign load_val[8] = bus.in8;
    assign load_val[9] = bus.in9;

    // One-hot decode; addresses past the last register match no entry and write nothing.
    always_comb begin
        wr_en_c = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            wr_en_c[k] = bus.writeAddress && (bus.address == ADDR_W'(k));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        data_reg_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (bus.writeAll),
            .load_val_i (load_val[g]),
            .wr_en_i    (wr_en_c[g]),
            .wr_val_i   (bus.dataIn),
            .q_o        (reg_q[g])
        );
    end

    assign bus.out0 = reg_q[0];
    assign bus.out1 = reg_q[1];
    assign bus.out2 = reg_q[2];
    assign bus.out3 = reg_q[3];
    assign bus.out4 = reg_q[4];
    assign bus.out5 = reg_q[5];
    assign bus.out6 = reg_q[6];
    assign bus.out7 = reg_q[7];
    assign bus.out8 = reg_q[8];
    assign bus.out9 = reg_q[9];

`ifdef DATA_REG_BANK_ADDR_ERR_EN
    logic addr_err_d;
    logic addr_err_q;

    // Flag an addressed write that lost no priority to writeAll yet hit no register.
    always_comb begin
        addr_err_d = bus.writeAddress && !bus.writeAll && !addr_in_range(bus.address);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.addrErr = addr_err_q;
`else
    // Out-of-range writes are dropped by the decode with no further indication.
`endif

endmodule

// File: tb/tb_data_reg_bank.sv
// Directed bench for data_reg_bank: expected bank images queued per edge, checked by a monitor.
module tb_data_reg_bank;
    import data_reg_bank_pkg::*;

    typedef struct packed {
        logic [NUM_REGS-1:0][DATA_W-1:0] regs;
        logic                            err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_reg_bank_if bus ();

    data_reg_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t  sb[$];
    data_t exp_regs [NUM_REGS];
    logic  exp_err;
    int    n_vec  = 0;
    int    n_fail = 0;

    function automatic data_t get_out(input int k);
        case (k)
            0: return bus.out0;
            1: return bus.out1;
            2: return bus.out2;
            3: return bus.out3;
            4: return bus.out4;
            5: return bus.out5;
            6: return bus.out6;
            7: return bus.out7;
            8: return bus.out8;
            default: return bus.out9;
        endcase
    endfunction

    task automatic set_in(input int k, input data_t v);
        case (k)
            0: bus.in0 = v;
            1: bus.in1 = v;
            2: bus.in2 = v;
            3: bus.in3 = v;
            4: bus.in4 = v;
            5: bus.in5 = v;
            6: bus.in6 = v;
            7: bus.in7 = v;
            8: bus.in8 = v;
            default: bus.in9 = v;
        endcase
    endtask

    // Capture edge, then queue the expected bank image visible after it.
    task automatic step();
        exp_t e;
        @(posedge clk);
        for (int k = 0; k < NUM_REGS; k++) e.regs[k] = exp_regs[k];
        e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares registered outputs mid-cycle against the oldest queued image.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t  e;
            data_t got;
            e = sb.pop_front();
            for (int k = 0; k < NUM_REGS; k++) begin
                got = get_out(k);
                n_vec++;
                if (got !== e.regs[k]) begin
                    n_fail++;
                    $display("FAIL out%0d @%0t: got %h expected %h", k, $time, got, e.regs[k]);
                end
            end
`ifdef DATA_REG_BANK_ADDR_ERR_EN
            n_vec++;
            if (bus.addrErr !== e.err) begin
                n_fail++;
                $display("FAIL addrErr @%0t: got %b expected %b", $time, bus.addrErr, e.err);
            end
`endif
        end
    end

    initial begin
        int waited;
        exp_err = 1'b0;

        // Reset overrides a simultaneous parallel load and addressed write.
        rst_n = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) set_in(k, 32'hFFFF_FFFF);
        bus.dataIn       = 32'hFFFF_FFFF;
        bus.address      = 4'd0;
        bus.writeAddress = 1'b1;
        bus.writeAll     = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 32'h0;
        step();
        rst_n            = 1'b1;
        bus.writeAll     = 1'b0;
        bus.writeAddress = 1'b0;
        step();

        // Addressed writes 0..9, with a hold edge after each.
        for (int k = 0; k < NUM_REGS; k++) begin
            bus.dataIn       = data_t'(k);
            bus.address      = addr_t'(k);
            bus.writeAddress = 1'b1;
            exp_regs[k]      = data_t'(k);
            step();
            bus.writeAddress = 1'b0;
            step();
        end

        // Parallel load 10..19, then inputs cleared with writeAll low.
        for (int k = 0; k < NUM_REGS; k++) begin
            set_in(k, data_t'(10 + k));
            exp_regs[k] = data_t'(10 + k);
        end
        bus.writeAll = 1'b1;
        step();
        bus.writeAll = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) set_in(k, 32'h0);
        step();
        step();

        // writeAll beats a same-cycle addressed write to register 3.
        for (int k = 0; k < NUM_REGS; k++) begin
            set_in(k, data_t'(32'h20 + k));
            exp_regs[k] = data_t'(32'h20 + k);
        end
        set_in(3, 32'h33);
        exp_regs[3]      = 32'h33;
        bus.writeAll     = 1'b1;
        bus.writeAddress = 1'b1;
        bus.address      = 4'd3;
        bus.dataIn       = 32'hAA;
        step();
        bus.writeAll     = 1'b0;
        bus.writeAddress = 1'b0;
        step();

        // Out-of-range addresses 12, 10, 15: no register changes, error pulses.
        bus.dataIn = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            bus.address      = (i == 0) ? 4'd12 : (i == 1) ? 4'd10 : 4'd15;
            bus.writeAddress = 1'b1;
            exp_err          = 1'b1;
            step();
            bus.writeAddress = 1'b0;
            exp_err          = 1'b0;
            step();
        end

        // writeAll with an out-of-range address: load happens, no error.
        for (int k = 0; k < NUM_REGS; k++) begin
            set_in(k, data_t'(32'h100 + k));
            exp_regs[k] = data_t'(32'h100 + k);
        end
        bus.writeAll     = 1'b1;
        bus.writeAddress = 1'b1;
        bus.address      = 4'd13;
        step();
        bus.writeAll     = 1'b0;
        bus.writeAddress = 1'b0;
        step();

        // Level-sensitive write: three edges at address 5 with dataIn 1,2,3.
        bus.address      = 4'd5;
        bus.writeAddress = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.dataIn  = data_t'(i);
            exp_regs[5] = data_t'(i);
            step();
        end
        bus.writeAddress = 1'b0;
        step();

        // Reset in mid-operation clears everything, including a pending error.
        bus.address      = 4'd14;
        bus.writeAddress = 1'b1;
        rst_n            = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 32'h0;
        exp_err          = 1'b0;
        step();
        rst_n            = 1'b1;
        bus.writeAddress = 1'b0;
        step();

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expected images left unchecked, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
